// File: rtl/s_dly_ctrl.sv
// Runtime-programmable single-bit delay line with a valid/ready reconfiguration handshake.
// Optional build macro S_DLY_CTRL_CLR_EN: clear the shift chain when a new delay is accepted.
module s_dly_ctrl #(
   parameter int MAX_DLY = 8,
   parameter int DW      = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_vld,
   input  logic [DW-1:0] cfg_dly,
   output logic          cfg_rdy,
   output logic          cfg_err,
   input  logic          d0,
   output logic          qn,
   output logic          qn_vld,
   output logic [DW-1:0] cur_dly
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

   localparam logic [DW-1:0] MAX_DLY_W = DW'(MAX_DLY);

   state_t               state_q, state_d;
   logic [MAX_DLY-1:0]   chain_q, chain_d;
   logic [DW-1:0]        cur_dly_q, cur_dly_d;
   logic [DW-1:0]        fill_cnt_q, fill_cnt_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 accept;
   logic                 over_max;
   logic                 clr_chain;
   logic                 tap;
   logic [DW-1:0]        req_dly;

   assign over_max = (cfg_dly > MAX_DLY_W);
   assign req_dly  = over_max ? MAX_DLY_W : cfg_dly;
   assign accept   = cfg_vld & cfg_rdy;

`ifdef S_DLY_CTRL_CLR_EN
   assign clr_chain = accept;
`else
   assign clr_chain = 1'b0;
`endif

   // The chain never stalls; it only optionally flushes on a new configuration.
   assign chain_d[0] = clr_chain ? 1'b0 : d0;
   genvar gi;
   generate
      for (gi = 1; gi < MAX_DLY; gi++) begin : g_chain
         assign chain_d[gi] = clr_chain ? 1'b0 : chain_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         chain_q    <= '0;
         cur_dly_q  <= '0;
         fill_cnt_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         chain_q    <= chain_d;
         cur_dly_q  <= cur_dly_d;
         fill_cnt_q <= fill_cnt_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_dly_d  = cur_dly_q;
      fill_cnt_d = fill_cnt_q;
      cfg_err_d  = 1'b0;
      case (state_q)
         S_FILL: begin
            fill_cnt_d = fill_cnt_q - 1'b1;
            if (fill_cnt_q == DW'(1)) begin
               state_d = S_RUN;
            end
         end
         default: begin
            if (accept) begin
               cur_dly_d = req_dly;
               cfg_err_d = over_max;
               if (req_dly == '0) begin
                  state_d = S_RUN;
               end else begin
                  state_d    = S_FILL;
                  fill_cnt_d = req_dly;
               end
            end
         end
      endcase
   end

   always_comb begin
      cfg_rdy = (state_q != S_FILL);
      qn_vld  = (state_q == S_RUN);
      tap     = d0;
      for (int i = 0; i < MAX_DLY; i++) begin
         if (cur_dly_q == DW'(i + 1)) begin
            tap = chain_q[i];
         end
      end
      qn = (state_q == S_IDLE) ? 1'b0 : tap;
   end

   assign cur_dly = cur_dly_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: doc/s_dly_ctrl.md
Name: s_dly_ctrl

Overview:
Runtime-programmable delay-line controller for a single-bit signal.
- Owns a MAX_DLY-deep shift chain and selects the output tap from a configured delay.
- Sequences reconfiguration with a valid/ready handshake and a fill phase, so downstream logic only sees delayed data after the new delay has been applied.
- Sits in front of consumers that today use fixed-latency flop chains but need the latency set by software or by a calibration FSM.

Parameters:
MAX_DLY, 8, maximum supported delay in clock cycles (>=1)
DW, 4, width of the delay configuration field; 2**DW must be > MAX_DLY

Ports:
clk  input  1  clock, all flops on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_vld  input  1  new delay configuration offered
cfg_dly  input  DW  requested delay in cycles, 0..MAX_DLY
cfg_rdy  output  1  controller can accept a configuration
cfg_err  output  1  one-cycle pulse: the accepted cfg_dly exceeded MAX_DLY and was clamped
d0  input  1  data in
qn  output  1  d0 delayed by the current delay
qn_vld  output  1  qn reflects the current delay setting
cur_dly  output  DW  delay currently applied

Behaviour:
Reset (async, rst_n=0):
- Shift chain and all registers cleared.
- State=IDLE, cur_dly=0, qn=0, qn_vld=0, cfg_rdy=1, cfg_err=0.

Shift chain:
- Shifts every cycle: chain[0]<=d0, chain[i]<=chain[i-1].
- The chain never stalls.

Output mux:
- cur_dly=0: qn=d0 (combinational).
- Otherwise qn=chain[cur_dly-1].
- In IDLE, qn is forced to 0.

Acceptance:
- Handshake: a configuration is accepted on a rising edge where cfg_vld=1 and cfg_rdy=1.
- On accept, cur_dly<=min(cfg_dly, MAX_DLY).
- cfg_err=1 for exactly the next cycle if cfg_dly>MAX_DLY.

States:
- IDLE: cfg_rdy=1, qn_vld=0. On accept:
  - delay N=0: go to RUN.
  - delay N>0: load fill_cnt<=N and go to FILL.
- FILL: cfg_rdy=0, qn_vld=0.
  - fill_cnt decrements every cycle.
  - When fill_cnt==1 (the decrement to 0 occurs on this edge), go to RUN.
  - cfg_vld is ignored; the requester holds it until ready.
- RUN: cfg_rdy=1, qn_vld=1. On accept, same as IDLE: N=0 stays in RUN, N>0 goes to FILL with qn_vld dropping the next cycle.

Latency:
- Accept at edge E0 with N>0: qn_vld rises after edge E_N, the N-th edge after E0.
- From then on, qn in cycle k equals d0 from cycle k-N.
- N=0: qn_vld=1 from the cycle after E0, and qn=d0.

Boundaries:
- cfg_dly=MAX_DLY selects chain[MAX_DLY-1].
- cfg_dly equal to the current value is still accepted and re-runs the fill.
- Back-to-back accepts in RUN with N=0 are allowed every cycle.
- fill_cnt is DW bits wide and never wraps.
- rst_n asserted during FILL or RUN returns to reset values immediately, with no pending configuration retained.

Optional Feature:
Macro S_DLY_CTRL_CLR_EN.
- Defined: on accept, the whole shift chain is cleared to 0 on the same edge (chain[0] loads 0, not d0). During FILL, qn therefore reads 0; the first valid qn after E_N is the d0 sampled one cycle after E0.
- Not defined: the chain keeps shifting through the accept. qn during FILL shows stale or mixed data, which is masked only by qn_vld=0.
- qn_vld timing is identical in both builds.

Test Plan:
1. Reset, then cfg_dly=3 accepted at E0; drive d0 pattern 1,0,1,1 -> cfg_rdy=0 for 3 cycles, qn_vld rises after E3, qn reproduces the pattern 3 cycles late, cur_dly=3.
2. In RUN, cfg_dly=0 -> qn_vld stays 1 (no fill), qn follows d0 combinationally in the next cycle, cfg_rdy stays 1.
3. cfg_dly=15 with MAX_DLY=8 -> cfg_err pulses for 1 cycle, cur_dly=8, qn_vld after 8 edges, qn=d0 delayed 8.
4. cfg_vld held high during FILL with a new value 5 -> not accepted until RUN; then accepted, qn_vld drops for 5 cycles.
5. rst_n pulsed low mid-FILL (N=6, fill_cnt=2) -> qn, qn_vld, cur_dly and cfg_err go to 0 asynchronously; after release, state is IDLE and cfg_rdy=1.
6. With S_DLY_CTRL_CLR_EN, chain full of 1s, reconfigure to 4 -> qn=0 during FILL. Without the macro -> qn shows stale 1s while qn_vld=0.
